// File: rtl/spi_cfg_target_if.sv
// SPI pad bundle between an external MCU (master) and the config target (slave).
//   spi_sclk / spi_cs_n / spi_mosi : driven by the MCU
//   spi_miso / spi_miso_oe         : driven by the target
interface spi_cfg_target_if;
    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (output spi_sclk, spi_cs_n, spi_mosi, input spi_miso, spi_miso_oe);
    modport slave  (input spi_sclk, spi_cs_n, spi_mosi, output spi_miso, spi_miso_oe);
endinterface

// File: rtl/spi_cfg_target.sv
// SPI mode-0 config target for the pedal control registers.
// SCLK/CS_N/MOSI are oversampled in the core clock domain (clk >= 8x SCLK).
// Frame: 16 bits MSB first, [15] rw (1=write), [14:8] addr, [7:0] data.
// Map: 0 thres, 1 slope, 2 gain, 3 ctrl[4:0], 4 status_in (ro), 5 ID_VALUE (ro).
// Ports:
//   clk, rst_n    core clock, async active-low reset
//   spi           SPI pads (slave modport)
//   status_in     live status byte, sampled at read-address decode
//   thres/slope/gain/ctrl  register outputs
//   cfg_update    one-cycle pulse when a write commits
//   frame_err     one-cycle pulse when a frame aborts early
// Build option: define SPI_CFG_READBACK_EN to build the read mux and MISO shifter;
// otherwise spi_miso/spi_miso_oe are tied low.
module spi_cfg_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter logic [7:0] THRES_RST   = 8'h80,
    parameter logic [7:0] SLOPE_RST   = 8'h10,
    parameter logic [7:0] GAIN_RST    = 8'h40
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_cfg_target_if.slave   spi,
    input  logic [7:0]        status_in,
    output logic [7:0]        thres,
    output logic [7:0]        slope,
    output logic [7:0]        gain,
    output logic [4:0]        ctrl,
    output logic              cfg_update,
    output logic              frame_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d, vld_pipe_q, vld_pipe_d;
    logic       sclk_prev_q, sclk_prev_d, armed_q, armed_d, commit_q, commit_d;
    logic       cfg_update_q, cfg_update_d, frame_err_q, frame_err_d;
    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_q, rx_d;
    logic [7:0] thres_q, thres_d, slope_q, slope_d, gain_q, gain_d;
    logic [4:0] ctrl_q, ctrl_d;

    logic sclk_s, cs_s, mosi_s, sclk_rise, vld_full, last_rise;
    logic [7:0] hdr;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    // Synchronizer outputs only reflect the pads once the reset values are flushed.
    assign vld_full  = &vld_pipe_q;
    assign last_rise = (state_q == DATA) && sclk_rise && (bit_cnt_q == 4'd15);
    // {rw, addr} as it will be after the 8th rise is shifted in
    assign hdr       = {rx_q[6:0], mosi_s};

`ifdef SPI_CFG_READBACK_EN
    logic [7:0] tx_q, tx_d, rd_byte;
    logic       miso_q, miso_d, sclk_fall;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    always_comb begin
        rd_byte = 8'h00;
        case (hdr[6:0])
            7'd0: rd_byte = thres_q;
            7'd1: rd_byte = slope_q;
            7'd2: rd_byte = gain_q;
            7'd3: rd_byte = {3'b000, ctrl_q};
            7'd4: rd_byte = status_in;
            7'd5: rd_byte = ID_VALUE;
            default: rd_byte = 8'h00;
        endcase
    end

    assign spi.spi_miso    = miso_q & ~cs_s;
    assign spi.spi_miso_oe = ~cs_s;
`else
    logic unused_status;
    assign unused_status   = ^status_in;
    assign spi.spi_miso    = 1'b0;
    assign spi.spi_miso_oe = 1'b0;
`endif

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi.spi_sclk};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], spi.spi_cs_n};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
        vld_pipe_d   = {vld_pipe_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d  = sclk_s;
        armed_d      = armed_q;
        commit_d     = 1'b0;
        cfg_update_d = 1'b0;
        frame_err_d  = 1'b0;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        thres_d      = thres_q;
        slope_d      = slope_q;
        gain_d       = gain_q;
        ctrl_d       = ctrl_q;
`ifdef SPI_CFG_READBACK_EN
        tx_d         = tx_q;
        miso_d       = miso_q;
`endif

        case (state_q)
            IDLE: begin
                // A frame starts only on a low seen after a genuine high on the pad,
                // so a CS held low across reset cannot open a frame.
                if (vld_full && cs_s) begin
                    armed_d = 1'b1;
                end else if (armed_q && !cs_s) begin
                    armed_d   = 1'b0;
                    state_d   = ADDR;
                    bit_cnt_d = 4'd0;
                end
            end
            ADDR, DATA: begin
                if (sclk_rise) begin
                    rx_d      = {rx_q[14:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (state_q == ADDR && bit_cnt_q == 4'd7) begin
                        state_d = DATA;
`ifdef SPI_CFG_READBACK_EN
                        tx_d = hdr[7] ? 8'h00 : rd_byte;
`endif
                    end
                    if (last_rise) begin
                        state_d  = DONE;
                        commit_d = 1'b1;
                    end
                end
                // A CS rise coincident with the 16th rise completes the frame.
                if (cs_s && !last_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end
            end
            DONE: if (cs_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef SPI_CFG_READBACK_EN
        if (state_q == DATA && sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
        end
        if (cs_s) miso_d = 1'b0;
`endif

        if (commit_q && rx_q[15] && rx_q[14:8] < 7'd4) begin
            cfg_update_d = 1'b1;
            case (rx_q[9:8])
                2'd0: thres_d = rx_q[7:0];
                2'd1: slope_d = rx_q[7:0];
                2'd2: gain_d  = rx_q[7:0];
                default: ctrl_d = rx_q[4:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            vld_pipe_q   <= '0;
            sclk_prev_q  <= 1'b0;
            armed_q      <= 1'b0;
            commit_q     <= 1'b0;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            rx_q         <= 16'h0000;
            thres_q      <= THRES_RST;
            slope_q      <= SLOPE_RST;
            gain_q       <= GAIN_RST;
            ctrl_q       <= 5'd0;
`ifdef SPI_CFG_READBACK_EN
            tx_q         <= 8'h00;
            miso_q       <= 1'b0;
`endif
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            vld_pipe_q   <= vld_pipe_d;
            sclk_prev_q  <= sclk_prev_d;
            armed_q      <= armed_d;
            commit_q     <= commit_d;
            cfg_update_q <= cfg_update_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            thres_q      <= thres_d;
            slope_q      <= slope_d;
            gain_q       <= gain_d;
            ctrl_q       <= ctrl_d;
`ifdef SPI_CFG_READBACK_EN
            tx_q         <= tx_d;
            miso_q       <= miso_d;
`endif
        end
    end

    assign thres      = thres_q;
    assign slope      = slope_q;
    assign gain       = gain_q;
    assign ctrl       = ctrl_q;
    assign cfg_update = cfg_update_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_spi_cfg_target.sv
// Randomized bench for spi_cfg_target: an MCU-side SPI driver, a register-map
// reference model and pulse counters for cfg_update / frame_err.
module tb_spi_cfg_target;
    localparam int HALF = 6;   // SCLK half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] status_in = 8'h00;
    logic [7:0] thres, slope, gain;
    logic [4:0] ctrl;
    logic       cfg_update, frame_err;

    spi_cfg_target_if spi_if();

    spi_cfg_target dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi        (spi_if),
        .status_in  (status_in),
        .thres      (thres),
        .slope      (slope),
        .gain       (gain),
        .ctrl       (ctrl),
        .cfg_update (cfg_update),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int n_upd = 0, n_ferr = 0;
    bit oe_seen = 1'b0;
    logic [7:0] m_reg [4];

    always @(posedge clk) begin
        if (cfg_update) n_upd++;
        if (frame_err) n_ferr++;
        if (spi_if.spi_miso_oe) oe_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clocks n bits of w (zeros past bit 16); returns MISO sampled before rises 8..15.
    task automatic spi_bits(input logic [15:0] w, input int n, output logic [7:0] rd);
        rd = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_if.spi_mosi = (i < 16) ? w[15-i] : 1'b0;
            wclk(HALF);
            if (i >= 8 && i < 16) rd = {rd[6:0], spi_if.spi_miso};
            spi_if.spi_sclk = 1'b1;
            wclk(HALF);
            spi_if.spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] w, input int n, output logic [7:0] rd);
        spi_if.spi_cs_n = 1'b0;
        wclk(4);
        spi_bits(w, n, rd);
        wclk(HALF);
        spi_if.spi_cs_n = 1'b1;
        wclk(10);
    endtask

    function automatic logic [7:0] exp_rd(input logic [6:0] a);
        if (a < 7'd4) return m_reg[a[1:0]];
        if (a == 7'd4) return status_in;
        if (a == 7'd5) return 8'hA5;
        return 8'h00;
    endfunction

    task automatic model_write(input logic [6:0] a, input logic [7:0] d);
        if (a < 7'd4) m_reg[a[1:0]] = (a == 7'd3) ? {3'b000, d[4:0]} : d;
    endtask

    task automatic check_regs(input string tag);
        @(negedge clk);
        chk({tag, ".thres"}, thres, m_reg[0]);
        chk({tag, ".slope"}, slope, m_reg[1]);
        chk({tag, ".gain"},  gain,  m_reg[2]);
        chk({tag, ".ctrl"},  ctrl,  m_reg[3]);
    endtask

    task automatic model_reset();
        m_reg[0] = 8'h80; m_reg[1] = 8'h10; m_reg[2] = 8'h40; m_reg[3] = 8'h00;
    endtask

    initial begin
        logic [7:0] rd, erd, d;
        logic [6:0] a;
        logic       rw;
        int u0, e0;

        spi_if.spi_sclk = 1'b0;
        spi_if.spi_cs_n = 1'b1;
        spi_if.spi_mosi = 1'b0;
        model_reset();
        wclk(3);
        @(negedge clk);
        chk("rst.miso", spi_if.spi_miso, 1'b0);
        chk("rst.oe", spi_if.spi_miso_oe, 1'b0);
        chk("rst.upd", cfg_update, 1'b0);
        chk("rst.ferr", frame_err, 1'b0);
        check_regs("rst");
        rst_n = 1'b1;
        wclk(5);

        // single write to reg 0
        u0 = n_upd;
        frame(16'h8033, 16, rd);
        model_write(7'd0, 8'h33);
        check_regs("wr0");
        chk("wr0.upd", n_upd - u0, 1);

        // ctrl write then readback, ID and unmapped reads
        frame(16'h8315, 16, rd);
        model_write(7'd3, 8'h15);
        check_regs("wr3");
        frame(16'h0300, 16, rd);
`ifdef SPI_CFG_READBACK_EN
        chk("rd3", rd, 8'h15);
`endif
        frame(16'h0500, 16, rd);
`ifdef SPI_CFG_READBACK_EN
        chk("rd5", rd, 8'hA5);
`endif
        frame(16'h4000, 16, rd);
`ifdef SPI_CFG_READBACK_EN
        chk("rd40", rd, 8'h00);
`endif

        // aborted write after 10 rises, then a full write
        u0 = n_upd; e0 = n_ferr;
        frame(16'h8177, 10, rd);
        check_regs("abort");
        chk("abort.ferr", n_ferr - e0, 1);
        chk("abort.upd", n_upd - u0, 0);
        frame(16'h8122, 16, rd);
        model_write(7'd1, 8'h22);
        check_regs("after_abort");

        // reset mid-frame, then a frame with CS held low across reset
        spi_if.spi_cs_n = 1'b0;
        wclk(4);
        spi_bits(16'h82FF, 12, rd);
        rst_n = 1'b0;
        wclk(3);
        model_reset();
        check_regs("midrst");
        rst_n = 1'b1;
        wclk(5);
        u0 = n_upd; e0 = n_ferr;
        spi_bits(16'h8201, 16, rd);
        wclk(HALF);
        spi_if.spi_cs_n = 1'b1;
        wclk(10);
        check_regs("nocs");
        chk("nocs.upd", n_upd - u0, 0);

        // 20 rises on one frame
        u0 = n_upd; e0 = n_ferr;
        frame(16'h8201, 20, rd);
        model_write(7'd2, 8'h01);
        check_regs("rise20");
        chk("rise20.upd", n_upd - u0, 1);
        chk("rise20.ferr", n_ferr - e0, 0);

        // randomized frames against the register-map model
        for (int k = 0; k < 40; k++) begin
            rw = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 5));
            d  = 8'($urandom);
            status_in = 8'($urandom);
            erd = exp_rd(a);
            u0 = n_upd; e0 = n_ferr;
            frame({rw, a, d}, 16, rd);
            if (rw) model_write(a, d);
            check_regs("rnd");
            chk("rnd.upd", n_upd - u0, (rw && a < 7'd4) ? 1 : 0);
            chk("rnd.ferr", n_ferr - e0, 0);
`ifdef SPI_CFG_READBACK_EN
            if (!rw) chk("rnd.rd", rd, erd);
`endif
        end

`ifndef SPI_CFG_READBACK_EN
        chk("oe_never", oe_seen, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
